// File: rtl/ball_motion_if.sv
// Bundles the VGA sync, launch, slider and ball-position signals between the
// frame timing/control side and the ball_motion engine.
interface ball_motion_if;
    logic       iVGA_VS;
    logic       iStart;
    logic [9:0] iSlider_x;
    logic [9:0] iSlider_y;
    logic [9:0] oBall_x;
    logic [9:0] oBall_y;
    logic       oBall_lost;
    logic [1:0] oState;

    modport master (
        output iVGA_VS, iStart, iSlider_x, iSlider_y,
        input  oBall_x, oBall_y, oBall_lost, oState
    );

    modport slave (
        input  iVGA_VS, iStart, iSlider_x, iSlider_y,
        output oBall_x, oBall_y, oBall_lost, oState
    );
endinterface

// File: rtl/ball_motion.sv
// Per-frame ball motion engine: moves the ball once per VS falling edge, bounces off walls/slider.
// Optional macro BALL_SPEEDUP_EN: step grows by 1 every 8th slider hit, saturating at SPEED+2.
module ball_motion #(
    parameter int unsigned SCREEN_W    = 640,
    parameter int unsigned SCREEN_H    = 480,
    parameter int unsigned BALL_SIZE   = 8,
    parameter int unsigned SLIDER_W    = 64,
    parameter int unsigned SPEED       = 2,
    parameter int unsigned LOST_FRAMES = 60,
    parameter int unsigned START_X     = 316,
    parameter int unsigned START_Y     = 400
) (
    input  logic         iVGA_CLK,
    input  logic         iRST_n,
    ball_motion_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_LOST = 2'b10;

    localparam int unsigned CNT_W = $clog2(LOST_FRAMES);

    localparam logic signed [11:0] C_BALL  = 12'(BALL_SIZE);
    localparam logic signed [11:0] C_SLW   = 12'(SLIDER_W);
    localparam logic signed [11:0] C_XMAX  = 12'(SCREEN_W - BALL_SIZE);
    localparam logic signed [11:0] C_YLIM  = 12'(SCREEN_H);
    localparam logic [9:0]         C_PARK  = 10'(SLIDER_W / 2 - BALL_SIZE / 2);
    localparam logic [9:0]         C_BALL10 = 10'(BALL_SIZE);
    localparam logic [2:0]         C_STEP0 = 3'(SPEED);
    localparam logic [CNT_W-1:0]   C_CNT_END = CNT_W'(LOST_FRAMES - 1);

    logic             r_vs_d;
    logic [1:0]       r_state;
    logic [9:0]       r_x;
    logic [9:0]       r_y;
    logic             r_dx_pos;
    logic             r_dy_pos;
    logic             r_pend;
    logic [CNT_W-1:0] r_cnt;
    logic             r_lost;

    logic             w_tick;
    logic [2:0]       w_step;
    logic signed [11:0] w_step12;
    logic signed [11:0] w_x12;
    logic signed [11:0] w_y12;
    logic signed [11:0] w_sx12;
    logic signed [11:0] w_sy12;
    logic signed [11:0] w_nx;
    logic signed [11:0] w_ny;
    logic             w_hit;

    logic [1:0]       w_state_nxt;
    logic [9:0]       w_x_nxt;
    logic [9:0]       w_y_nxt;
    logic             w_dx_nxt;
    logic             w_dy_nxt;
    logic             w_pend_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_lost_nxt;

    assign w_tick   = r_vs_d & ~bus.iVGA_VS;
    assign w_step12 = $signed({9'd0, w_step});
    assign w_x12    = $signed({2'b00, r_x});
    assign w_y12    = $signed({2'b00, r_y});
    assign w_sx12   = $signed({2'b00, bus.iSlider_x});
    assign w_sy12   = $signed({2'b00, bus.iSlider_y});
    assign w_nx     = r_dx_pos ? w_x12 + w_step12 : w_x12 - w_step12;
    assign w_ny     = r_dy_pos ? w_y12 + w_step12 : w_y12 - w_step12;

    // Slider contact uses the old y so the ball must cross the slider top this frame.
    assign w_hit = r_dy_pos && (w_ny + C_BALL >= w_sy12) && (w_y12 + C_BALL <= w_sy12) &&
                   (w_nx + C_BALL > w_sx12) && (w_nx < w_sx12 + C_SLW);

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_dx_nxt    = r_dx_pos;
        w_dy_nxt    = r_dy_pos;
        w_pend_nxt  = r_pend;
        w_cnt_nxt   = r_cnt;
        w_lost_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_pend_nxt = r_pend | bus.iStart;
                if (w_tick) begin
                    w_x_nxt = bus.iSlider_x + C_PARK;
                    w_y_nxt = bus.iSlider_y - C_BALL10;
                    if (r_pend | bus.iStart) begin
                        w_state_nxt = ST_RUN;
                        w_dx_nxt    = 1'b1;
                        w_dy_nxt    = 1'b0;
                        w_pend_nxt  = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (w_tick) begin
                    if (w_nx <= 12'sd0) begin
                        w_x_nxt  = '0;
                        w_dx_nxt = 1'b1;
                    end else if (w_nx >= C_XMAX) begin
                        w_x_nxt  = C_XMAX[9:0];
                        w_dx_nxt = 1'b0;
                    end else begin
                        w_x_nxt = w_nx[9:0];
                    end
                    if (w_hit) begin
                        w_y_nxt  = bus.iSlider_y - C_BALL10;
                        w_dy_nxt = 1'b0;
                    end else if (w_ny <= 12'sd0) begin
                        w_y_nxt  = '0;
                        w_dy_nxt = 1'b1;
                    end else if (w_ny + C_BALL >= C_YLIM) begin
                        w_y_nxt     = w_ny[9:0];
                        w_state_nxt = ST_LOST;
                        w_cnt_nxt   = '0;
                        w_lost_nxt  = 1'b1;
                    end else begin
                        w_y_nxt = w_ny[9:0];
                    end
                end
            end
            ST_LOST: begin
                w_pend_nxt = 1'b0;
                if (w_tick) begin
                    if (r_cnt == C_CNT_END) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_pend_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_vs_d   <= 1'b0;
            r_state  <= ST_IDLE;
            r_x      <= 10'(START_X);
            r_y      <= 10'(START_Y);
            r_dx_pos <= 1'b1;
            r_dy_pos <= 1'b0;
            r_pend   <= 1'b0;
            r_cnt    <= '0;
            r_lost   <= 1'b0;
        end else begin
            r_vs_d   <= bus.iVGA_VS;
            r_state  <= w_state_nxt;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_dx_pos <= w_dx_nxt;
            r_dy_pos <= w_dy_nxt;
            r_pend   <= w_pend_nxt;
            r_cnt    <= w_cnt_nxt;
            r_lost   <= w_lost_nxt;
        end
    end

`ifdef BALL_SPEEDUP_EN
    localparam logic [2:0] C_STEP_MAX = 3'(SPEED + 2);

    logic [2:0] r_step;
    logic [2:0] r_hits;
    logic       w_to_idle;
    logic       w_hit_evt;

    assign w_to_idle = (w_state_nxt == ST_IDLE) && (r_state != ST_IDLE);
    assign w_hit_evt = (r_state == ST_RUN) && w_tick && w_hit;

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_step <= C_STEP0;
            r_hits <= '0;
        end else if (w_to_idle) begin
            r_step <= C_STEP0;
            r_hits <= '0;
        end else if (w_hit_evt) begin
            r_hits <= r_hits + 3'd1;
            if (r_hits == 3'd7 && r_step < C_STEP_MAX) begin
                r_step <= r_step + 3'd1;
            end
        end
    end

    assign w_step = r_step;
`else
    assign w_step = C_STEP0;
`endif

    assign bus.oBall_x    = r_x;
    assign bus.oBall_y    = r_y;
    assign bus.oBall_lost = r_lost;
    assign bus.oState     = r_state;

endmodule
